pc_sequencer: RTL and testbench

- Fetch/decode/execute controller that sequences the 8-bit program counter.
- Drives the counter's CountEn, Load and load address.
- Requests instructions from instruction memory over a req/ack handshake.
- Implements jumps, conditional branches and call/return through a small internal return-address stack.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_ret_stack.sv | 43 ++++
 rtl/pc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// opcode values and the controller state encoding.
package pc_seq_pkg;

    localparam int AW_DEF    = 8;
    localparam int OPW_DEF   = 4;
    localparam int DEPTH_DEF = 4;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_JMP  = 1;
    localparam int unsigned OP_JZ   = 2;
    localparam int unsigned OP_JNZ  = 3;
    localparam int unsigned OP_CALL = 4;
    localparam int unsigned OP_RET  = 5;
    localparam int unsigned OP_HALT = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADPC = 3'd1,
        FETCH  = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        HALTED = 3'd5,
        ERROR  = 3'd6
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Memory-fetch and counter-control signals between the sequencer (master)
// and the surrounding program counter / instruction memory (slave).
interface pc_sequencer_if #(
    parameter int AW  = 8,
    parameter int OPW = 4
);
    // Fetch handshake: MemReq stays high every cycle until MemAck is seen;
    // MemData is captured on the clock edge where MemReq && MemAck; MemAck
    // while MemReq is low has no effect. The fetch address is PcIn.
    logic                 MemReq;
    logic                 MemAck;
    logic [OPW+AW-1:0]    MemData;
    logic [AW-1:0]        PcIn;
    logic                 CountEn;
    logic                 Load;
    logic [AW-1:0]        LoadAddr;

    modport master (
        output MemReq, CountEn, Load, LoadAddr,
        input  MemAck, MemData, PcIn
    );

    modport slave (
        input  MemReq, CountEn, Load, LoadAddr,
        output MemAck, MemData, PcIn
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Pushes when full and pops when empty are dropped;
// dout_o always shows the top entry (0 when empty).
module pc_ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] din_i,
    output logic [AW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] top_idx;
    logic [AW-1:0]  mem_q [DEPTH];

    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_idx = sp_q - SPW'(1);
    assign dout_o  = empty_o ? '0 : mem_q[top_idx[IW-1:0]];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[sp_q[IW-1:0]] <= din_i;
            sp_q                <= sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller steering an external program counter,
// with jumps, conditional branches and call/return via pc_ret_stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           Clk,
    input  logic           nReset,
    input  logic           Start,
    input  logic [AW-1:0]  StartAddr,
    input  logic           ZeroFlag,
    pc_sequencer_if.master bus,
    output logic           Busy,
    output logic           Halted,
    output logic           StackErr,
    output state_e         DbgState
);

    state_e            state_q, state_d;
    logic [OPW+AW-1:0] ir_q, ir_d;
    logic              act_load_q, act_load_d;
    logic              act_push_q, act_push_d;
    logic              act_pop_q, act_pop_d;
    logic              act_halt_q, act_halt_d;
    logic [AW-1:0]     act_addr_q, act_addr_d;

    logic [OPW-1:0]    op;
    logic [AW-1:0]     operand;
    logic              is_call, is_ret;
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [AW-1:0]     stk_dout;

    logic              mem_req, count_en, load;
    logic [AW-1:0]     load_addr;

    assign op      = ir_q[OPW+AW-1:AW];
    assign operand = ir_q[AW-1:0];
    assign is_call = (op == OPW'(OP_CALL));
    assign is_ret  = (op == OPW'(OP_RET));

    // The stack only moves in EXEC, so PcIn still holds the CALL's own address.
    assign stk_push = (state_q == EXEC) && act_push_q;
    assign stk_pop  = (state_q == EXEC) && act_pop_q;

    pc_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .Clk     (Clk),
        .nReset  (nReset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (bus.PcIn + AW'(1)),
        .dout_o  (stk_dout),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            act_load_q <= 1'b0;
            act_push_q <= 1'b0;
            act_pop_q  <= 1'b0;
            act_halt_q <= 1'b0;
            act_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            act_load_q <= act_load_d;
            act_push_q <= act_push_d;
            act_pop_q  <= act_pop_d;
            act_halt_q <= act_halt_d;
            act_addr_q <= act_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        act_load_d = act_load_q;
        act_push_d = act_push_q;
        act_pop_d  = act_pop_q;
        act_halt_d = act_halt_q;
        act_addr_d = act_addr_q;
        mem_req    = 1'b0;
        count_en   = 1'b0;
        load       = 1'b0;
        load_addr  = '0;
        Busy       = 1'b0;
        Halted     = 1'b0;
        StackErr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    act_addr_d = StartAddr;
                    state_d    = LOADPC;
                end
            end
            LOADPC: begin
                Busy      = 1'b1;
                load      = 1'b1;
                load_addr = act_addr_q;
                state_d   = FETCH;
            end
            FETCH: begin
                Busy    = 1'b1;
                mem_req = 1'b1;
                if (bus.MemAck) begin
                    ir_d    = bus.MemData;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Resolve the whole EXEC action here so EXEC is a pure register readout.
                Busy       = 1'b1;
                act_load_d = 1'b0;
                act_push_d = 1'b0;
                act_pop_d  = 1'b0;
                act_halt_d = 1'b0;
                act_addr_d = operand;
                if (op == OPW'(OP_JMP)) begin
                    act_load_d = 1'b1;
                end else if (op == OPW'(OP_JZ)) begin
                    act_load_d = ZeroFlag;
                end else if (op == OPW'(OP_JNZ)) begin
                    act_load_d = !ZeroFlag;
                end else if (is_call) begin
                    act_load_d = 1'b1;
                    act_push_d = 1'b1;
                end else if (is_ret) begin
                    act_load_d = 1'b1;
                    act_pop_d  = 1'b1;
                    act_addr_d = stk_dout;
                end else if (op == OPW'(OP_HALT)) begin
                    act_halt_d = 1'b1;
                end
                if ((is_call && stk_full) || (is_ret && stk_empty)) begin
                    state_d = ERROR;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                Busy = 1'b1;
                if (act_load_q) begin
                    load      = 1'b1;
                    load_addr = act_addr_q;
                end else begin
                    count_en = 1'b1;
                end
                state_d = act_halt_q ? HALTED : FETCH;
            end
            HALTED: begin
                Halted = 1'b1;
                if (Start) begin
                    state_d = FETCH;
                end
            end
            ERROR: begin
                StackErr = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.MemReq   = mem_req;
    assign bus.CountEn  = count_en;
    assign bus.Load     = load;
    assign bus.LoadAddr = load_addr;
    assign DbgState     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: program counter + instruction memory environment,
// an instruction-level reference interpreter, and directed/random scenarios.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW = 8;
  localparam int OPW = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic zero_flag;
  logic busy, halted, stack_err;
  state_e dbg_state;

  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(AW), .OPW(OPW)) bus ();

  pc_sequencer #(.AW(AW), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .Clk(clk),
    .nReset(rst_n),
    .Start(start),
    .StartAddr(start_addr),
    .ZeroFlag(zero_flag),
    .bus(bus),
    .Busy(busy),
    .Halted(halted),
    .StackErr(stack_err),
    .DbgState(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- environment: counter, memory, flag ----------------
  logic [OPW+AW-1:0] mem [256];
  logic zf_map [256];
  logic [AW-1:0] pc;
  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  int max_rand_wait = 2;
  int wcnt = 0;
  int cur_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (bus.Load) pc <= bus.LoadAddr;
    else if (bus.CountEn) pc <= pc + AW'(1);
  end

  assign bus.PcIn = pc;
  assign zero_flag = zf_map[pc];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.MemAck = 1'b0;
      bus.MemData = '0;
      wcnt = 0;
      cur_wait = fixed_wait;
    end else if (bus.MemReq) begin
      if (wcnt >= cur_wait) begin
        bus.MemAck = 1'b1;
        bus.MemData = mem[pc];
      end else begin
        bus.MemAck = 1'b0;
        wcnt++;
      end
    end else begin
      bus.MemAck = 1'b0;
      wcnt = 0;
      cur_wait = rand_wait ? int'($urandom_range(max_rand_wait, 0)) : fixed_wait;
    end
  end

  // ---------------- monitor: observed counter actions ----------------
  logic [AW:0] obs_q[$];
  int obs_t[$];
  int cyc = 0;
  int both_cnt = 0;
  int req_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Load) begin
        obs_q.push_back({1'b1, bus.LoadAddr});
        obs_t.push_back(cyc);
      end else if (bus.CountEn) begin
        obs_q.push_back({1'b0, {AW{1'b0}}});
        obs_t.push_back(cyc);
      end
      if (bus.Load && bus.CountEn) both_cnt++;
      if (bus.MemReq) req_cnt++;
    end
  end

  // ---------------- reference interpreter ----------------
  logic [AW:0] exp_q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack[$];
  int m_status = 0; // 0 running, 1 halted, 2 stack error

  task automatic model_reset();
    exp_q.delete();
    m_stack.delete();
    m_status = 0;
  endtask

  task automatic model_start(input logic [AW-1:0] a);
    m_pc = a;
    m_status = 0;
    exp_q.push_back({1'b1, a});
  endtask

  task automatic model_run(input int limit);
    for (int n = 0; n < limit && m_status == 0; n++) begin
      logic [OPW-1:0] op;
      logic [AW-1:0] arg;
      logic [AW-1:0] ret;
      logic taken;
      op = mem[m_pc][OPW+AW-1:AW];
      arg = mem[m_pc][AW-1:0];
      taken = 1'b0;
      if (op == OPW'(OP_JMP)) taken = 1'b1;
      else if (op == OPW'(OP_JZ)) taken = zf_map[m_pc];
      else if (op == OPW'(OP_JNZ)) taken = !zf_map[m_pc];
      if (op == OPW'(OP_CALL)) begin
        if (m_stack.size() == DEPTH) m_status = 2;
        else begin
          m_stack.push_back(m_pc + AW'(1));
          exp_q.push_back({1'b1, arg});
          m_pc = arg;
        end
      end else if (op == OPW'(OP_RET)) begin
        if (m_stack.size() == 0) m_status = 2;
        else begin
          ret = m_stack.pop_back();
          exp_q.push_back({1'b1, ret});
          m_pc = ret;
        end
      end else if (taken) begin
        exp_q.push_back({1'b1, arg});
        m_pc = arg;
      end else begin
        exp_q.push_back({1'b0, {AW{1'b0}}});
        m_pc = m_pc + AW'(1);
        if (op == OPW'(OP_HALT)) m_status = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [OPW+AW-1:0] ins(input int unsigned op, input logic [AW-1:0] a);
    return {OPW'(op), a};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      zf_map[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    obs_t.delete();
    both_cnt = 0;
    req_cnt = 0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int want_len, input int want_status, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= want_len &&
          (want_status == 0 || (want_status == 1 && halted) || (want_status == 2 && stack_err))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [AW+5:0] outs;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    outs = {bus.MemReq, bus.CountEn, bus.Load, bus.LoadAddr, busy, halted, stack_err};
    n_checks++;
    if (outs !== '0) begin n_errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    n_checks++;
    if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== IDLE || busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle_hold got state %0d busy %b want IDLE busy 0", dbg_state, busy);
    end
  endtask

  task automatic test_straight();
    bit ok;
    logic [AW:0] g;
    fixed_wait = 0;
    rand_wait = 1'b0;
    do_reset();
    clear_prog();
    mem[1] = ins(OP_NOP, 8'h00);
    mem[2] = ins(OP_NOP, 8'h00);
    mem[3] = ins(OP_HALT, 8'h00);
    model_start(8'd1);
    model_run(10);
    pulse_start(8'd1);
    wait_done(exp_q.size(), 1, 200, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL straight_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL straight_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL straight_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    for (int i = 1; i < 4 && i < obs_t.size(); i++) begin
      n_checks++;
      if (obs_t[i] - obs_t[i-1] != 3) begin n_errors++; $display("FAIL straight_gap[%0d] got %0d want 3", i, obs_t[i] - obs_t[i-1]); end
    end
    n_checks++;
    if (pc !== 8'd4 || halted !== 1'b1) begin n_errors++; $display("FAIL straight_halt got pc %0d halted %b want pc 4 halted 1", pc, halted); end
    n_checks++;
    if (both_cnt != 0) begin n_errors++; $display("FAIL straight_exclusive got %0d want 0", both_cnt); end
  endtask

  task automatic test_jmp_wrap();
    bit ok;
    logic [AW:0] g;
    do_reset();
    clear_prog();
    mem[1] = ins(OP_JMP, 8'd250);
    mem[0] = ins(OP_HALT, 8'h00);
    model_start(8'd1);
    model_run(20);
    pulse_start(8'd1);
    wait_done(exp_q.size(), 1, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL wrap_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL wrap_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL wrap_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    n_checks++;
    if (pc !== 8'd1) begin n_errors++; $display("FAIL wrap_final_pc got %0d want 1", pc); end
  endtask

  task automatic test_branches();
    bit ok;
    logic [AW:0] g;
    do_reset();
    clear_prog();
    mem[1] = ins(OP_JZ, 8'h40);    zf_map[1] = 1'b1;
    mem[8'h40] = ins(OP_JZ, 8'h40);  zf_map[8'h40] = 1'b0;
    mem[8'h41] = ins(OP_JNZ, 8'h60); zf_map[8'h41] = 1'b0;
    mem[8'h60] = ins(OP_JNZ, 8'h10); zf_map[8'h60] = 1'b1;
    mem[8'h61] = ins(OP_HALT, 8'h00);
    model_start(8'd1);
    model_run(20);
    pulse_start(8'd1);
    wait_done(exp_q.size(), 1, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL branch_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL branch_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL branch_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    n_checks++;
    if (pc !== 8'h62) begin n_errors++; $display("FAIL branch_final_pc got %h want 62", pc); end
  endtask

  task automatic test_call_ret();
    bit ok;
    logic [AW:0] g;
    fixed_wait = 3;
    do_reset();
    clear_prog();
    mem[8'h10] = ins(OP_CALL, 8'h80);
    mem[8'h80] = ins(OP_RET, 8'h00);
    mem[8'h11] = ins(OP_HALT, 8'h00);
    model_start(8'h10);
    model_run(20);
    pulse_start(8'h10);
    wait_done(exp_q.size(), 1, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL callret_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL callret_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL callret_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      n_checks++;
      if (obs_t[i] - obs_t[i-1] != 6) begin n_errors++; $display("FAIL callret_gap[%0d] got %0d want 6", i, obs_t[i] - obs_t[i-1]); end
    end
    n_checks++;
    if (req_cnt != 12) begin n_errors++; $display("FAIL callret_memreq_cycles got %0d want 12", req_cnt); end
    fixed_wait = 0;
  endtask

  task automatic test_halt_resume();
    bit ok;
    logic [AW:0] g;
    do_reset();
    clear_prog();
    mem[8'h00] = ins(OP_CALL, 8'h20);
    mem[8'h20] = ins(OP_HALT, 8'h00);
    mem[8'h21] = ins(OP_RET, 8'h00);
    mem[8'h01] = ins(OP_HALT, 8'h00);
    model_start(8'h00);
    model_run(20);
    pulse_start(8'h00);
    wait_done(exp_q.size(), 1, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL resume_first_halt got 0 want 1"); end
    m_status = 0;
    model_run(20);
    pulse_start(8'h99);
    pulse_start(8'h55);
    wait_done(exp_q.size(), 1, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL resume_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL resume_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL resume_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    n_checks++;
    if (pc !== 8'h02) begin n_errors++; $display("FAIL resume_final_pc got %h want 02", pc); end
  endtask

  task automatic test_stack_err();
    bit ok;
    logic [AW:0] g;
    int obs_before, req_before;
    do_reset();
    clear_prog();
    for (int i = 0; i < 5; i++) mem[i] = ins(OP_CALL, AW'(i + 1));
    model_start(8'h00);
    model_run(20);
    pulse_start(8'h00);
    wait_done(exp_q.size(), 2, 300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL overflow_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL overflow_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_checks++;
      if (g !== exp_q[i]) begin n_errors++; $display("FAIL overflow_action[%0d] got %h want %h", i, g, exp_q[i]); end
    end
    obs_before = obs_q.size();
    req_before = req_cnt;
    pulse_start(8'h33);
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (stack_err !== 1'b1 || dbg_state !== ERROR || bus.MemReq !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL overflow_sticky got err %b state %0d req %b busy %b want 1 %0d 0 0", stack_err, dbg_state, bus.MemReq, busy, ERROR);
    end
    n_checks++;
    if (obs_q.size() != obs_before || req_cnt != req_before) begin
      n_errors++; $display("FAIL overflow_quiet got actions %0d reqs %0d want %0d %0d", obs_q.size(), req_cnt, obs_before, req_before);
    end
    do_reset();
    #1;
    n_checks++;
    if (stack_err !== 1'b0) begin n_errors++; $display("FAIL err_cleared got %b want 0", stack_err); end
    clear_prog();
    mem[0] = ins(OP_RET, 8'h00);
    model_start(8'h00);
    model_run(5);
    pulse_start(8'h00);
    wait_done(exp_q.size(), 2, 100, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL underflow_timeout got 0 want 1"); end
    n_checks++;
    if (obs_q.size() != 1) begin n_errors++; $display("FAIL underflow_len got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    logic [AW+5:0] outs;
    fixed_wait = 20;
    do_reset();
    clear_prog();
    pulse_start(8'h05);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = bus.MemReq;
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.MemReq !== 1'b1) begin n_errors++; $display("FAIL midfetch_req got %b want 1", bus.MemReq); end
    #1;
    rst_n = 1'b0;
    #1;
    outs = {bus.MemReq, bus.CountEn, bus.Load, bus.LoadAddr, busy, halted, stack_err};
    n_checks++;
    if (outs !== '0 || dbg_state !== IDLE) begin
      n_errors++; $display("FAIL midfetch_async got %h state %0d want 0 state %0d", outs, dbg_state, IDLE);
    end
    fixed_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== IDLE || bus.MemReq !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL midfetch_stay_idle got state %0d req %b busy %b want IDLE 0 0", dbg_state, bus.MemReq, busy);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [AW:0] g;
    logic [AW-1:0] a;
    rand_wait = 1'b1;
    max_rand_wait = 2;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        mem[i] = {OPW'($urandom_range(OP_HALT + 2, 0)), AW'($urandom_range(255, 0))};
        zf_map[i] = 1'($urandom_range(1, 0));
      end
      a = AW'($urandom_range(255, 0));
      model_start(a);
      model_run(30);
      pulse_start(a);
      wait_done(exp_q.size(), m_status, 1000, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL random%0d_timeout got 0 want 1", it); end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL random%0d_len got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        g = (i < obs_q.size()) ? obs_q[i] : 'x;
        n_checks++;
        if (g !== exp_q[i]) begin n_errors++; $display("FAIL random%0d_action[%0d] got %h want %h", it, i, g, exp_q[i]); end
      end
      n_checks++;
      if (halted !== (m_status == 1) || stack_err !== (m_status == 2)) begin
        n_errors++; $display("FAIL random%0d_status got halted %b err %b want status %0d", it, halted, stack_err, m_status);
      end
      n_checks++;
      if (both_cnt != 0) begin n_errors++; $display("FAIL random%0d_exclusive got %0d want 0", it, both_cnt); end
    end
    rand_wait = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_prog();
    test_reset();
    test_straight();
    test_jmp_wrap();
    test_branches();
    test_call_ret();
    test_halt_resume();
    test_stack_err();
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
